hazard_scheduler: RTL and testbench
===================================

# hazard_scheduler

Stall, flush and multiply/divide busy sequencer for the five-stage MIPS pipeline. It decides each cycle whether the F/D pipeline register and PC hold, whether the D/E register is cleared into a bubble, and tracks the multi-cycle HI/LO unit. Its `STALL_EN_N` output drives the hold input of the F/D exception-info register. It also resolves priority between a stall, a CP0 exception/interrupt request `Req`, and an `ERET` in decode.

## Interface

Parameters:
- `MULT_CYC`, default 5: busy cycles after a mult/multu start.
- `DIV_CYC`, default 10: busy cycles after a div/divu start.

Ports:
- `clk` in 1: clock.
- `RESET` in 1: reset, synchronous, active-high.
- `Req` in 1: CP0 exception/interrupt request, M stage.
- `D_rs`, `D_rt` in 5 each: decode source register numbers.
- `D_Tuse_rs`, `D_Tuse_rt` in 2 each: cycles until the value is needed; 3 means unused.
- `E_wa` in 5, `E_Tnew` in 2: E-stage destination and cycles until result.
- `M_wa` in 5, `M_Tnew` in 2: M-stage destination and Tnew.
- `D_uses_md` in 1: decode instruction is mult/div/mfhi/mflo/mthi/mtlo.
- `E_start_mult`, `E_start_div` in 1 each: start pulse from E, one cycle.
- `D_ERET` in 1: decode holds eret.
- `E_mtc0_epc`, `M_mtc0_epc` in 1 each: mtc0 to EPC in E / M.
- `STALL_EN_N` out 1: 1 means PC and F/D hold; 0 means load.
- `E_CLR` out 1: clear the D/E register (bubble).
- `ERET_GO` out 1: eret may redirect this cycle.
- `MD_BUSY` out 1: HI/LO unit busy.
- `STALL_CNT` out 32: count of stalled cycles.

## Operation

- `stall_data`:
  - Set if `D_rs != 0` and `D_rs == E_wa` and `D_Tuse_rs < E_Tnew`.
  - Same check for rs against M using `M_Tnew`.
  - Same two checks for rt.
  - Register 0 never causes a hazard.
- `stall_md` = `D_uses_md & (E_start_mult | E_start_div | MD_BUSY)`.
- `stall_eret` = `D_ERET & (E_mtc0_epc | M_mtc0_epc)`.
- `stall` = `stall_data | stall_md | stall_eret`.
- Priority, highest first:
  - `RESET`
  - `Req`: `STALL_EN_N=0`, `E_CLR=1`, `ERET_GO=0`; all registers take the handler path.
  - `stall`: `STALL_EN_N=1`, `E_CLR=1`, `ERET_GO=0`.
  - Otherwise: `STALL_EN_N=0`, `E_CLR=0`, `ERET_GO=D_ERET`.
- MD counter: 4-bit down-counter `cnt`; `MD_BUSY = (cnt != 0)`.
  - A start with `Req=0` loads `MULT_CYC` or `DIV_CYC`. If both start pulses are high, `E_start_div` wins.
  - A start with `Req=1` is ignored; that instruction is being flushed.
  - A started operation is never aborted by a later `Req`; `cnt` keeps decrementing.
  - A start while `cnt != 0` cannot occur, because `stall_md` prevents it.
  - With no start and `cnt != 0`, `cnt` decrements by 1.
- `STALL_CNT` increments on every cycle with `stall & ~Req & ~RESET`. It wraps 0xFFFFFFFF→0.

## Timing

- Stall, clear and `ERET_GO` outputs are combinational from the inputs and `cnt`.
- `cnt` and `STALL_CNT` are registered.
- While `RESET` is high: `STALL_EN_N=0`, `E_CLR=1`, `ERET_GO=0`, and `MD_BUSY=0` from the next edge onward.
- On the edge with `RESET=1`: `cnt←0`, `STALL_CNT←0`. Reset in the middle of a mult/div drops it.
- MD sequence: start seen at edge t → `MD_BUSY=1` for cycles t+1 … t+`MULT_CYC` → 0 at t+`MULT_CYC`+1.
  - A dependent decode instruction stalls from the start cycle through the last busy cycle.
  - It issues in the first cycle with `MD_BUSY=0`.
- `Req` and `stall` in the same cycle: `Req` wins, and `STALL_CNT` does not increment.
- `ERET_GO` and `Req` are never both 1.

## Structure

- Shared header/package holds:
  - Tnew/Tuse encodings: 0–2 meaningful, 3 = never.
  - Default `MULT_CYC`/`DIV_CYC`.
  - The `PC_INIT`/`HANDLE_START` address map, which is already shared.
- One sub-module, `md_busy_counter`, takes `clk`, `RESET`, start pulses and `Req`, and outputs `busy`.
- The rest is combinational compare logic plus `STALL_CNT` in the top.

## Test plan

- **Data hazard.** lw writes $8 (E, `E_Tnew=2`); decode addu reads $8 (`Tuse=1`).
  - Required: `STALL_EN_N=1` and `E_CLR=1` for 1 cycle, then 0.
  - With `E_wa=0`: no stall.
- **Mult sequencing.** `E_start_mult` at t, `D_uses_md=1` held.
  - Required: stall at t … t+5, release at t+6, `MD_BUSY` high at t+1 … t+5.
  - Div variant: release at t+11.
- **Req overrides stall.** `Req=1` together with an active data stall.
  - Required: `STALL_EN_N=0`, `E_CLR=1`, `STALL_CNT` unchanged.
  - `Req` with `E_start_div` in the same cycle: `MD_BUSY` stays 0.
- **ERET gating.** `D_ERET=1` with `M_mtc0_epc=1`.
  - Required: `ERET_GO=0` and stall.
  - Next cycle with no mtc0: `ERET_GO=1`, `STALL_EN_N=0`.
- **Reset mid-div.** Assert `RESET` 3 cycles after a div start.
  - Required: `MD_BUSY=0` and `STALL_CNT=0` after the edge; `E_CLR=1` during reset.
- **Counter wrap.** Preload `STALL_CNT` to 0xFFFFFFFF via force, then one stall cycle.
  - Required: reads 0.

Source files
------------

// File: rtl/hazard_scheduler_pkg.sv
// Shared pipeline encodings and address map used by the hazard scheduler and its neighbours.
package hazard_scheduler_pkg;

  // Tnew/Tuse: 0..2 are cycle distances, 3 means the value is never produced/needed.
  localparam logic [1:0] T_0     = 2'd0;
  localparam logic [1:0] T_1     = 2'd1;
  localparam logic [1:0] T_2     = 2'd2;
  localparam logic [1:0] T_NEVER = 2'd3;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  localparam logic [31:0] PC_INIT      = 32'h0000_3000;
  localparam logic [31:0] HANDLE_START = 32'h0000_4180;

  // A source hazards against a producer when it needs the value before it exists.
  function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                      input logic [4:0] wa, input logic [1:0] tnew);
    return (src != 5'd0) && (src == wa) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/hazard_scheduler_if.sv
// Decode/execute/memory hazard inputs and pipeline control outputs of the scheduler.
interface hazard_scheduler_if;
  logic        Req;
  logic [4:0]  D_rs;
  logic [4:0]  D_rt;
  logic [1:0]  D_Tuse_rs;
  logic [1:0]  D_Tuse_rt;
  logic [4:0]  E_wa;
  logic [1:0]  E_Tnew;
  logic [4:0]  M_wa;
  logic [1:0]  M_Tnew;
  logic        D_uses_md;
  logic        E_start_mult;
  logic        E_start_div;
  logic        D_ERET;
  logic        E_mtc0_epc;
  logic        M_mtc0_epc;
  logic        STALL_EN_N;
  logic        E_CLR;
  logic        ERET_GO;
  logic        MD_BUSY;
  logic [31:0] STALL_CNT;

  // Inputs are level signals sampled each cycle; there is no valid/ready handshake.
  modport master (
    output Req, D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, E_wa, E_Tnew, M_wa, M_Tnew,
           D_uses_md, E_start_mult, E_start_div, D_ERET, E_mtc0_epc, M_mtc0_epc,
    input  STALL_EN_N, E_CLR, ERET_GO, MD_BUSY, STALL_CNT
  );

  modport slave (
    input  Req, D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, E_wa, E_Tnew, M_wa, M_Tnew,
           D_uses_md, E_start_mult, E_start_div, D_ERET, E_mtc0_epc, M_mtc0_epc,
    output STALL_EN_N, E_CLR, ERET_GO, MD_BUSY, STALL_CNT
  );
endinterface

// File: rtl/hazard_scheduler_md_busy_counter.sv
// Busy tracker for the multi-cycle HI/LO unit: loads on a start, counts down to idle.
module md_busy_counter
  import hazard_scheduler_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic RESET,
  input  logic start_mult,
  input  logic start_div,
  input  logic Req,
  output logic busy
);

  logic [3:0] cnt;

  // A start that coincides with Req belongs to a flushed instruction; a running op is never aborted.
  always_ff @(posedge clk) begin
    if (RESET) begin
      cnt <= 4'd0;
    end else if (!Req && start_div) begin
      cnt <= 4'(DIV_CYC);
    end else if (!Req && start_mult) begin
      cnt <= 4'(MULT_CYC);
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign busy = (cnt != 4'd0);

endmodule

// File: rtl/hazard_scheduler.sv
// Stall/flush/ERET priority logic for the five-stage pipeline plus stalled-cycle counter.
module hazard_scheduler
  import hazard_scheduler_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input logic clk,
  input logic RESET,
  hazard_scheduler_if.slave hs
);

  logic        md_busy;
  logic        stall_data;
  logic        stall_md;
  logic        stall_eret;
  logic        stall;
  logic [31:0] stall_cnt_q;

  md_busy_counter #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md (
    .clk        (clk),
    .RESET      (RESET),
    .start_mult (hs.E_start_mult),
    .start_div  (hs.E_start_div),
    .Req        (hs.Req),
    .busy       (md_busy)
  );

  always_comb begin
    stall_data = src_hazard(hs.D_rs, hs.D_Tuse_rs, hs.E_wa, hs.E_Tnew)
               | src_hazard(hs.D_rs, hs.D_Tuse_rs, hs.M_wa, hs.M_Tnew)
               | src_hazard(hs.D_rt, hs.D_Tuse_rt, hs.E_wa, hs.E_Tnew)
               | src_hazard(hs.D_rt, hs.D_Tuse_rt, hs.M_wa, hs.M_Tnew);
    stall_md   = hs.D_uses_md & (hs.E_start_mult | hs.E_start_div | md_busy);
    stall_eret = hs.D_ERET & (hs.E_mtc0_epc | hs.M_mtc0_epc);
    stall      = stall_data | stall_md | stall_eret;
  end

  // Reset and Req both flush; Req must not freeze F/D so the handler fetch can proceed.
  always_comb begin
    hs.STALL_EN_N = 1'b0;
    hs.E_CLR      = 1'b0;
    hs.ERET_GO    = 1'b0;
    if (RESET || hs.Req) begin
      hs.E_CLR = 1'b1;
    end else if (stall) begin
      hs.STALL_EN_N = 1'b1;
      hs.E_CLR      = 1'b1;
    end else begin
      hs.ERET_GO = hs.D_ERET;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      stall_cnt_q <= 32'd0;
    end else if (stall && !hs.Req) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign hs.MD_BUSY   = md_busy;
  assign hs.STALL_CNT = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed and random stimulus for hazard_scheduler against a cycle-indexed reference model.
module tb_hazard_scheduler;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic RESET;
  int   errors = 0;
  int   checks = 0;

  // Model state: absolute cycle number, last busy cycle of the HI/LO unit, stall count.
  int          cyc;
  int          busy_end;
  logic [31:0] m_scnt;

  hazard_scheduler_if hif();

  hazard_scheduler #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) dut (
    .clk   (clk),
    .RESET (RESET),
    .hs    (hif)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic idle();
    hif.Req = 0; hif.D_rs = 0; hif.D_rt = 0; hif.D_Tuse_rs = 2'd3; hif.D_Tuse_rt = 2'd3;
    hif.E_wa = 0; hif.E_Tnew = 0; hif.M_wa = 0; hif.M_Tnew = 0; hif.D_uses_md = 0;
    hif.E_start_mult = 0; hif.E_start_div = 0; hif.D_ERET = 0;
    hif.E_mtc0_epc = 0; hif.M_mtc0_epc = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic model_busy();
    return cyc <= busy_end;
  endfunction

  function automatic logic model_stall();
    logic [4:0] src [2];
    logic [1:0] use_t [2];
    logic [4:0] wa [2];
    logic [1:0] tn [2];
    logic       s;
    src[0] = hif.D_rs; src[1] = hif.D_rt;
    use_t[0] = hif.D_Tuse_rs; use_t[1] = hif.D_Tuse_rt;
    wa[0] = hif.E_wa; wa[1] = hif.M_wa;
    tn[0] = hif.E_Tnew; tn[1] = hif.M_Tnew;
    s = 0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        if (src[i] != 0 && src[i] == wa[j] && int'(use_t[i]) < int'(tn[j])) s = 1;
    if (hif.D_uses_md && (hif.E_start_mult || hif.E_start_div || model_busy())) s = 1;
    if (hif.D_ERET && (hif.E_mtc0_epc || hif.M_mtc0_epc)) s = 1;
    return s;
  endfunction

  // Inputs are set just after a falling edge; check, then advance one rising edge.
  task automatic tick();
    logic s;
    logic exp_hold, exp_clr, exp_eret;
    #1;
    s = model_stall();
    if (RESET || hif.Req) begin
      exp_hold = 0; exp_clr = 1; exp_eret = 0;
    end else if (s) begin
      exp_hold = 1; exp_clr = 1; exp_eret = 0;
    end else begin
      exp_hold = 0; exp_clr = 0; exp_eret = hif.D_ERET;
    end
    chk("STALL_EN_N", 32'(hif.STALL_EN_N), 32'(exp_hold));
    chk("E_CLR",      32'(hif.E_CLR),      32'(exp_clr));
    chk("ERET_GO",    32'(hif.ERET_GO),    32'(exp_eret));
    chk("MD_BUSY",    32'(hif.MD_BUSY),    32'(model_busy()));
    chk("STALL_CNT",  hif.STALL_CNT,       m_scnt);
    @(posedge clk);
    if (RESET) begin
      busy_end = -1;
      m_scnt   = 0;
    end else begin
      if (s && !hif.Req) m_scnt = m_scnt + 1;
      if (!hif.Req && hif.E_start_div) busy_end = cyc + DIV_N;
      else if (!hif.Req && hif.E_start_mult) busy_end = cyc + MULT_N;
    end
    cyc++;
    @(negedge clk);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    cyc = 0; busy_end = -1; m_scnt = 0;
    RESET = 1; idle();
    @(negedge clk);
    tick(); tick();
    RESET = 0;

    // data hazard: lw in E writes $8, addu in D reads $8 at Tuse=1
    hif.E_wa = 5'd8; hif.E_Tnew = 2'd2; hif.D_rs = 5'd8; hif.D_Tuse_rs = 2'd1;
    tick();
    hif.E_wa = 0; hif.E_Tnew = 0; hif.M_wa = 5'd8; hif.M_Tnew = 2'd1;
    tick();
    idle(); hif.E_wa = 0; hif.E_Tnew = 2'd2; hif.D_rt = 0; hif.D_Tuse_rt = 2'd0;
    tick();
    // rt against M
    idle(); hif.M_wa = 5'd9; hif.M_Tnew = 2'd2; hif.D_rt = 5'd9; hif.D_Tuse_rt = 2'd0;
    tick();

    // mult then div sequencing with a dependent decode instruction held
    idle(); hif.D_uses_md = 1; hif.E_start_mult = 1;
    tick();
    hif.E_start_mult = 0;
    repeat (MULT_N + 1) tick();
    hif.E_start_div = 1;
    tick();
    hif.E_start_div = 0;
    repeat (DIV_N + 1) tick();
    // both starts: div wins
    idle(); hif.E_start_mult = 1; hif.E_start_div = 1;
    tick();
    idle();
    repeat (DIV_N + 1) tick();

    // Req overrides a data stall; Req kills a same-cycle div start
    idle(); hif.E_wa = 5'd4; hif.E_Tnew = 2'd2; hif.D_rs = 5'd4; hif.D_Tuse_rs = 2'd0; hif.Req = 1;
    tick();
    idle(); hif.Req = 1; hif.E_start_div = 1;
    tick();
    idle();
    tick();

    // ERET gated by pending mtc0 EPC
    idle(); hif.D_ERET = 1; hif.M_mtc0_epc = 1;
    tick();
    hif.M_mtc0_epc = 0;
    tick();
    hif.E_mtc0_epc = 1;
    tick();
    idle();

    // reset in the middle of a div
    hif.E_start_div = 1;
    tick();
    idle(); hif.D_uses_md = 1;
    tick(); tick();
    RESET = 1;
    tick();
    RESET = 0;
    tick(); tick();

    // STALL_CNT wrap
    idle();
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.stall_cnt_q;
    m_scnt = 32'hFFFF_FFFF;
    hif.D_ERET = 1; hif.E_mtc0_epc = 1;
    tick();
    idle();
    tick();

    // random traffic, registers kept in a small range so hazards are frequent
    for (int n = 0; n < 400; n++) begin
      RESET = ($urandom_range(0, 49) == 0);
      hif.Req       = ($urandom_range(0, 9) == 0);
      hif.D_rs      = 5'($urandom_range(0, 3));
      hif.D_rt      = 5'($urandom_range(0, 3));
      hif.D_Tuse_rs = 2'($urandom_range(0, 3));
      hif.D_Tuse_rt = 2'($urandom_range(0, 3));
      hif.E_wa      = 5'($urandom_range(0, 3));
      hif.E_Tnew    = 2'($urandom_range(0, 3));
      hif.M_wa      = 5'($urandom_range(0, 3));
      hif.M_Tnew    = 2'($urandom_range(0, 3));
      hif.D_uses_md = ($urandom_range(0, 2) == 0);
      hif.D_ERET    = ($urandom_range(0, 5) == 0);
      hif.E_mtc0_epc = ($urandom_range(0, 3) == 0);
      hif.M_mtc0_epc = ($urandom_range(0, 3) == 0);
      hif.E_start_mult = 0;
      hif.E_start_div  = 0;
      // a start can only follow an issued md instruction, never while busy
      if (!model_busy()) begin
        hif.E_start_mult = ($urandom_range(0, 7) == 0);
        hif.E_start_div  = ($urandom_range(0, 9) == 0);
      end
      tick();
    end
    RESET = 0; idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
